// File: rtl/decodificador_mfd.sv
// Serial receiver and inverse mapper for the +/-1 code-conversion circuit.
// Recovers XYZ from a framed {tag,A,B,C} word and presents it on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for a strobed start bit
// RX    | shifting in tag, A, B, C (bit count 0..3)
// HOLD  | result presented, waiting for out_ready
module decodificador_mfd #(
   parameter int ERR_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ser_en,
   input  logic             ser_in,
   input  logic             out_ready,
   input  logic             clr_err,
   output logic             out_valid,
   output logic [2:0]       out_xyz,
   output logic             out_err,
   output logic [ERR_W-1:0] err_count,
   output logic             ovf,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RX   = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   state_t           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [2:0]       shift_q, shift_d;
   logic [2:0]       xyz_q, xyz_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] errcnt_q, errcnt_d;
   logic             ovf_q, ovf_d;

   logic             start;
   logic             accept;

   // Returns {err, xyz}; codes 3 and 4 are resolved by the tag.
   function automatic logic [3:0] decode(input logic tag, input logic [2:0] c);
      logic [3:0] r;
      r = 4'b1000;
      if (!tag) begin
         if (c >= 3'd1 && c <= 3'd4) r = {1'b0, c - 3'd1};
      end else begin
         if (c >= 3'd3 && c <= 3'd6) r = {1'b0, c + 3'd1};
      end
      return r;
   endfunction

   assign start  = ser_en & ser_in;
   assign accept = (state_q == ST_HOLD) & out_ready;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      xyz_d    = xyz_q;
      err_d    = err_q;
      errcnt_d = errcnt_q;
      ovf_d    = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RX;
               cnt_d   = 2'd0;
               shift_d = 3'd0;
            end
         end
         ST_RX: begin
            if (ser_en) begin
               shift_d = {shift_q[1:0], ser_in};
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d        = ST_HOLD;
                  {err_d, xyz_d} = decode(shift_q[2], {shift_q[1:0], ser_in});
               end
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               // a start bit in the handshake cycle opens the next frame immediately
               if (start) begin
                  state_d = ST_RX;
                  cnt_d   = 2'd0;
                  shift_d = 3'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (start) begin
               ovf_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept && err_q && errcnt_q != ERR_MAX) errcnt_d = errcnt_q + ERR_ONE;

      if (clr_err) begin
         errcnt_d = '0;
         ovf_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 2'd0;
         shift_q  <= 3'd0;
         xyz_q    <= 3'd0;
         err_q    <= 1'b0;
         errcnt_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         xyz_q    <= xyz_d;
         err_q    <= err_d;
         errcnt_q <= errcnt_d;
         ovf_q    <= ovf_d;
      end
   end

   assign out_valid = (state_q == ST_HOLD);
   assign out_xyz   = xyz_q;
   assign out_err   = err_q;
   assign err_count = errcnt_q;
   assign ovf       = ovf_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_decodificador_mfd.sv
// Directed bench for decodificador_mfd; a second instance with ERR_W=2 shares
// the stimulus so counter saturation can be reached with few frames.
module tb_decodificador_mfd;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ser_en = 1'b0;
   logic       ser_in = 1'b0;
   logic       out_ready = 1'b0;
   logic       clr_err = 1'b0;

   logic       out_valid, out_err, ovf, busy;
   logic [2:0] out_xyz;
   logic [3:0] err_count;

   logic       w2_valid, w2_err, w2_ovf, w2_busy;
   logic [2:0] w2_xyz;
   logic [1:0] w2_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   decodificador_mfd u_dut (
      .clk(clk), .rst_n(rst_n), .ser_en(ser_en), .ser_in(ser_in),
      .out_ready(out_ready), .clr_err(clr_err),
      .out_valid(out_valid), .out_xyz(out_xyz), .out_err(out_err),
      .err_count(err_count), .ovf(ovf), .busy(busy)
   );

   decodificador_mfd #(.ERR_W(2)) u_dut_w2 (
      .clk(clk), .rst_n(rst_n), .ser_en(ser_en), .ser_in(ser_in),
      .out_ready(out_ready), .clr_err(clr_err),
      .out_valid(w2_valid), .out_xyz(w2_xyz), .out_err(w2_err),
      .err_count(w2_count), .ovf(w2_ovf), .busy(w2_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b, input int gap);
      ser_en = 1'b1;
      ser_in = b;
      @(posedge clk); #1;
      ser_en = 1'b0;
      ser_in = 1'b0;
      for (int i = 0; i < gap; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_frame(input logic tag, input logic [2:0] c, input int gap);
      send_bit(1'b1, gap);
      send_bit(tag, gap);
      send_bit(c[2], gap);
      send_bit(c[1], gap);
      send_bit(c[0], 0);
   endtask

   task automatic accept();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   typedef struct {
      logic       tag;
      logic [2:0] c;
      logic [2:0] xyz;
   } vec_t;

   vec_t good_vecs[4];
   vec_t bad_vecs[3];

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      good_vecs[0] = '{1'b0, 3'b100, 3'b011};
      good_vecs[1] = '{1'b1, 3'b011, 3'b100};
      good_vecs[2] = '{1'b1, 3'b110, 3'b111};
      good_vecs[3] = '{1'b0, 3'b001, 3'b000};
      bad_vecs[0]  = '{1'b1, 3'b000, 3'b000};
      bad_vecs[1]  = '{1'b1, 3'b001, 3'b000};
      bad_vecs[2]  = '{1'b0, 3'b111, 3'b000};

      // reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_xyz", out_xyz, 0);
      check("rst_err", out_err, 0);
      check("rst_cnt", err_count, 0);
      check("rst_ovf", ovf, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // reset mid-frame after two data bits
      send_bit(1'b1, 0);
      send_bit(1'b0, 0);
      send_bit(1'b0, 0);
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      #2;
      check("mrst_busy", busy, 0);
      check("mrst_valid", out_valid, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_frame(1'b0, 3'b010, 0);
      check("post_rst_valid", out_valid, 1);
      check("post_rst_xyz", out_xyz, 3'b001);
      check("post_rst_err", out_err, 0);
      accept();
      check("post_acc_valid", out_valid, 0);

      // valid decodes with 3-cycle gaps
      foreach (good_vecs[i]) begin
         send_frame(good_vecs[i].tag, good_vecs[i].c, 3);
         check($sformatf("good%0d_valid", i), out_valid, 1);
         check($sformatf("good%0d_xyz", i), out_xyz, good_vecs[i].xyz);
         check($sformatf("good%0d_err", i), out_err, 0);
         accept();
      end
      check("good_cnt", err_count, 0);

      // error frames and counter
      send_frame(1'b0, 3'b000, 0);
      check("e0_err", out_err, 1);
      check("e0_xyz", out_xyz, 0);
      accept();
      check("e0_cnt", err_count, 1);
      send_frame(1'b1, 3'b111, 1);
      check("e1_err", out_err, 1);
      check("e1_xyz", out_xyz, 0);
      accept();
      check("e1_cnt", err_count, 2);
      check("e1_cnt_w2", w2_count, 2);
      foreach (bad_vecs[i]) begin
         send_frame(bad_vecs[i].tag, bad_vecs[i].c, 0);
         check($sformatf("bad%0d_err", i), out_err, 1);
         accept();
      end
      check("sat_cnt_w2", w2_count, 3);
      check("sat_cnt", err_count, 5);
      send_frame(1'b0, 3'b101, 0);
      check("clr_frame_err", out_err, 1);
      clr_err = 1'b1;
      accept();
      clr_err = 1'b0;
      check("clr_cnt", err_count, 0);
      check("clr_cnt_w2", w2_count, 0);

      // backpressure with a start bit while held
      send_frame(1'b1, 3'b100, 0);
      check("bp_xyz", out_xyz, 3'b101);
      @(posedge clk); #1;
      send_bit(1'b1, 0);
      send_bit(1'b0, 0);
      send_bit(1'b0, 0);
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      check("bp_ovf", ovf, 1);
      check("bp_valid", out_valid, 1);
      check("bp_hold_xyz", out_xyz, 3'b101);
      check("bp_hold_err", out_err, 0);
      accept();
      check("bp_acc_valid", out_valid, 0);
      check("bp_acc_busy", busy, 0);
      send_frame(1'b0, 3'b011, 0);
      check("bp_next_xyz", out_xyz, 3'b010);
      accept();
      check("bp_ovf_sticky", ovf, 1);
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
      check("ovf_clr", ovf, 0);

      // back-to-back: start bit in the handshake cycle
      send_frame(1'b0, 3'b100, 0);
      check("b2b_first", out_xyz, 3'b011);
      out_ready = 1'b1;
      ser_en = 1'b1;
      ser_in = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      ser_en = 1'b0;
      ser_in = 1'b0;
      check("b2b_valid_drop", out_valid, 0);
      check("b2b_busy", busy, 1);
      send_bit(1'b1, 1);
      send_bit(1'b1, 1);
      send_bit(1'b0, 1);
      send_bit(1'b1, 0);
      check("b2b_valid", out_valid, 1);
      check("b2b_xyz", out_xyz, 3'b110);
      check("b2b_err", out_err, 0);
      accept();

      // idle noise
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1);
      check("noise_busy", busy, 0);
      check("noise_valid", out_valid, 0);
      check("noise_xyz", out_xyz, 3'b110);
      check("noise_ovf", ovf, 0);
      check("noise_cnt", err_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
